// File: rtl/gcd_arbiter.sv
// ============================================================================
// Module   : gcd_arbiter
// Purpose  : Round-robin sharing of one binary-GCD core between NREQ
//            requesters, with local bypass of zero operands.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gcd_arbiter #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              CEN,
  input  logic [NREQ-1:0]   Req,
  input  logic [8*NREQ-1:0] Ain_bus,
  input  logic [8*NREQ-1:0] Bin_bus,
  output logic [NREQ-1:0]   Gnt,
  output logic [NREQ-1:0]   Done_pulse,
  output logic [7:0]        Result,
  output logic [IDW-1:0]    Result_id,
  output logic              Busy,
  output logic [15:0]       Served_cnt,
  output logic              Core_Start,
  output logic              Core_Ack,
  output logic [7:0]        Core_Ain,
  output logic [7:0]        Core_Bin,
  output logic              Core_CEN,
  input  logic              Core_q_I,
  input  logic              Core_q_Done,
  input  logic [7:0]        Core_GCD
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RUN    = 3'd2,
    S_ACK    = 3'd3,
    S_WAIT_I = 3'd4,
    S_BYPASS = 3'd5
  } state_t;

  localparam logic [IDW:0]   c_NREQ   = (IDW+1)'(NREQ);
  localparam logic [IDW-1:0] c_LAST   = IDW'(NREQ-1);
  localparam logic [IDW-1:0] c_ID_ONE = IDW'(1);
  localparam logic [NREQ-1:0] c_OH_ONE = NREQ'(1);

  state_t          r_state;
  logic [IDW-1:0]  r_rr_ptr;
  logic [IDW-1:0]  r_id;
  logic [7:0]      r_opa;
  logic [7:0]      r_opb;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] r_done;
  logic [7:0]      r_result;
  logic [IDW-1:0]  r_result_id;
  logic [15:0]     r_served;
  logic            r_start;
  logic            r_ack;

  logic            w_found;
  logic [IDW-1:0]  w_idx;
  logic [IDW:0]    w_sum;
  logic [7:0]      w_a;
  logic [7:0]      w_b;
  logic [NREQ-1:0] w_id_oh;
  logic [NREQ-1:0] w_req_oh;
  logic [IDW-1:0]  w_next_ptr;
  logic [7:0]      w_byp;

  // Rotating-priority search: the first set Req bit at or after r_rr_ptr.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    w_sum   = '0;
    w_a     = '0;
    w_b     = '0;
    for (int i = 0; i < NREQ; i++) begin
      w_sum = {1'b0, r_rr_ptr} + i[IDW:0];
      if (w_sum >= c_NREQ) begin
        w_sum = w_sum - c_NREQ;
      end
      if (!w_found && Req[w_sum[IDW-1:0]]) begin
        w_found = 1'b1;
        w_idx   = w_sum[IDW-1:0];
      end
    end
    for (int k = 0; k < NREQ; k++) begin
      if (k[IDW-1:0] == w_idx) begin
        w_a = Ain_bus[8*k +: 8];
        w_b = Bin_bus[8*k +: 8];
      end
    end
  end

  assign w_id_oh    = c_OH_ONE << r_id;
  assign w_req_oh   = c_OH_ONE << w_idx;
  assign w_next_ptr = (r_id == c_LAST) ? '0 : r_id + c_ID_ONE;
  assign w_byp      = (r_opa != 8'd0) ? r_opa : r_opb;

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_opa       <= '0;
      r_opb       <= '0;
      r_gnt       <= '0;
      r_done      <= '0;
      r_result    <= '0;
      r_result_id <= '0;
      r_served    <= '0;
      r_start     <= 1'b0;
      r_ack       <= 1'b0;
    end else begin
      r_done <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_found && Core_q_I) begin
            r_id  <= w_idx;
            r_gnt <= w_req_oh;
            r_opa <= w_a;
            r_opb <= w_b;
            // The core never terminates on a zero operand, so answer locally.
            if ((w_a == 8'd0) || (w_b == 8'd0)) begin
              r_state <= S_BYPASS;
            end else begin
              r_start <= 1'b1;
              r_state <= S_LOAD;
            end
          end
        end
        S_LOAD: begin
          r_start <= 1'b0;
          r_state <= S_RUN;
        end
        S_RUN: begin
          if (Core_q_Done) begin
            r_result    <= Core_GCD;
            r_result_id <= r_id;
            r_ack       <= 1'b1;
            r_done      <= w_id_oh & {NREQ{Req[r_id]}};
            r_served    <= r_served + 16'd1;
            r_state     <= S_ACK;
          end
        end
        S_ACK: begin
          r_ack   <= 1'b0;
          r_state <= S_WAIT_I;
        end
        S_WAIT_I: begin
          if (Core_q_I) begin
            r_gnt    <= '0;
            r_rr_ptr <= w_next_ptr;
            r_state  <= S_IDLE;
          end
        end
        S_BYPASS: begin
          r_result    <= w_byp;
          r_result_id <= r_id;
          r_done      <= w_id_oh & {NREQ{Req[r_id]}};
          r_served    <= r_served + 16'd1;
          r_gnt       <= '0;
          r_rr_ptr    <= w_next_ptr;
          r_state     <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign Gnt        = r_gnt;
  assign Done_pulse = r_done;
  assign Result     = r_result;
  assign Result_id  = r_result_id;
  assign Busy       = (r_state != S_IDLE);
  assign Served_cnt = r_served;
  assign Core_Start = r_start;
  assign Core_Ack   = r_ack;
  assign Core_Ain   = r_opa;
  assign Core_Bin   = r_opb;
  assign Core_CEN   = (r_state == S_RUN) & CEN;

endmodule

`default_nettype wire

// File: doc/gcd_arbiter.md
Name: gcd_arbiter

Overview:
- Round-robin arbiter and sequencer that shares one binary-GCD core (Start/Ack handshake, CEN single-step, one-hot q_I/q_Sub/q_Mult/q_Done) between NREQ requesters.
- Captures the granted requester's operands, drives the core's handshake and returns the result with a one-cycle tagged completion pulse.
- Screens out zero operands locally, because the core does not terminate on them.
- Sits between the game-logic requesters and the single GCD datapath instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, width of Result_id; must equal ceil(log2(NREQ)).

Ports:
- Clk  in  1  system clock, rising edge.
- Reset  in  1  asynchronous, active-low reset (asserted at 0).
- CEN  in  1  single-step enable, forwarded to the core.
- Req  in  NREQ  request lines; bit k belongs to requester k.
- Ain_bus  in  8*NREQ  operand A; requester k uses bits [8k+7:8k].
- Bin_bus  in  8*NREQ  operand B, same packing as Ain_bus.
- Gnt  out  NREQ  one-hot grant, held from grant until completion.
- Done_pulse  out  NREQ  one-hot, high for one cycle when the result is valid.
- Result  out  8  GCD of the last served request; held until the next completion.
- Result_id  out  IDW  index of the last served requester.
- Busy  out  1  high in every state except IDLE.
- Served_cnt  out  16  completed requests; wraps from 0xFFFF to 0.
- Core_Start  out  1  core Start.
- Core_Ack  out  1  core Ack.
- Core_Ain  out  8  core Ain.
- Core_Bin  out  8  core Bin.
- Core_CEN  out  1  core CEN.
- Core_q_I  in  1  core in its initial state.
- Core_q_Done  in  1  core in its done state.
- Core_GCD  in  8  core AB_GCD.

Behaviour:
- Reset (Reset=0, async) forces:
  - state=IDLE, rr_ptr=0.
  - Gnt=0, Done_pulse=0, Result=0, Result_id=0, Busy=0, Served_cnt=0.
  - Core_Start=0, Core_Ack=0, latched operands=0.
- States: IDLE, LOAD, RUN, ACK, WAIT_I, BYPASS.
- IDLE:
  - If any Req bit is high and Core_q_I=1, grant the first requester at or after rr_ptr, wrapping modulo NREQ.
  - At the same edge: latch that requester's operands into opA/opB and set Gnt.
  - If opA==0 or opB==0, next state is BYPASS; otherwise LOAD.
- LOAD: Core_Start=1 for exactly one cycle; next state RUN.
- RUN:
  - Core_CEN=CEN; Core_Start=0.
  - When Core_q_Done=1, capture Result<=Core_GCD and Result_id<=granted index; next state ACK.
- ACK:
  - Core_Ack=1 for exactly one cycle.
  - Done_pulse[id]=1 in the same cycle, only if Req[id] is still high.
  - Served_cnt increments whether or not Done_pulse fires; next state WAIT_I.
- WAIT_I:
  - Wait for Core_q_I=1, then clear Gnt.
  - Set rr_ptr=(id+1) mod NREQ; next state IDLE.
- BYPASS:
  - Result = the nonzero operand, or 0 if both are zero.
  - Raise Done_pulse (same Req rule as ACK) and increment Served_cnt.
  - Clear Gnt, set rr_ptr=(id+1) mod NREQ; next state IDLE. The core is never started.
- Core_Ain/Core_Bin are driven from opA/opB at all times, so they are stable before and during Start.
- Core_CEN=0 outside RUN.
- Latency: with the arbiter idle, Req rising before edge 0 gives Gnt after edge 0 and Core_Start high during cycle 1.
  - Done_pulse occurs one cycle after the first Core_q_Done cycle.
  - A bypass request gives Done_pulse one cycle after grant.
- Requester contract: hold Req high and operands stable until Done_pulse; Done_pulse serves as the acknowledge.
  - Operand changes after grant are ignored.
  - If Req drops mid-operation, the core still runs to completion and is acked, the result is discarded (no Done_pulse), and Result/Result_id still update.
- Simultaneous requests are granted in rotating priority: starting at rr_ptr, the first set Req bit wins.
- CEN held low in RUN stalls the core indefinitely. There is no timeout; Busy stays high.
- Reset mid-operation aborts the arbiter immediately. The core shares the reset net and returns to its initial state.

Test Plan:
- Single request: Req=0001, A0=36, B0=24, CEN=1 -> one Core_Start pulse; then Done_pulse=0001, Result=12, Result_id=0, Served_cnt=1, Gnt clears.
- Contention: Req=1111 held, pairs (12,18),(7,5),(64,48),(9,9) -> service order 0,1,2,3 with Results 6,1,16,9; then order wraps back to 0.
- Zero bypass: Req=0100, A2=0, B2=45 -> Done_pulse=0100 one cycle after grant, Result=45, Core_Start never asserted; (0,0) gives Result=0.
- Withdrawal: Req=0010 with (40,30), Req drops while in RUN -> Core_Ack still pulses, no Done_pulse, Served_cnt increments, next grant proceeds normally.
- Single-step: CEN low for 20 cycles in RUN, then pulsed -> no Done_pulse while CEN=0; Result is correct after enough CEN pulses.
- Reset mid-RUN: Reset=0 -> all outputs reach reset values asynchronously; after release, a new request completes correctly.
